// File: rtl/tpm_reg_arbiter.sv
// tpm_reg_arbiter: shares one TPM register file between the SPI front-end and
// on-chip firmware. A single access runs at a time. SPI wins ties unless
// firmware has been passed over STARVE_MAX consecutive times.
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   spi_req_i/we_i/addr_i/wdata_i  SPI request (level, held until ack)
//   spi_ack_o, spi_rdata_o         SPI completion pulse and read data
//   spi_wait_o                     wait-state request to the SPI front-end
//   fw_*                           firmware requester, same meaning as spi_*
//   reg_addr_o, reg_data_o         register-file address / write data
//   reg_wr_o, reg_rd_o             one-cycle write / read strobes
//   reg_rdata_i                    register-file read data, RD_LAT after reg_rd_o
module tpm_reg_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              spi_req_i,
    input  logic              spi_we_i,
    input  logic [ADDR_W-1:0] spi_addr_i,
    input  logic [DATA_W-1:0] spi_wdata_i,
    output logic              spi_ack_o,
    output logic [DATA_W-1:0] spi_rdata_o,
    output logic              spi_wait_o,

    input  logic              fw_req_i,
    input  logic              fw_we_i,
    input  logic [ADDR_W-1:0] fw_addr_i,
    input  logic [DATA_W-1:0] fw_wdata_i,
    output logic              fw_ack_o,
    output logic [DATA_W-1:0] fw_rdata_o,

    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_data_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [DATA_W-1:0] reg_rdata_i
);

    localparam int unsigned LAT_W    = 3;
    localparam int unsigned STARVE_W = 4;
    localparam logic        OWNER_SPI = 1'b0;
    localparam logic        OWNER_FW  = 1'b1;
    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(RD_LAT);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                reg_wr_q, reg_wr_d;
    logic                reg_rd_q, reg_rd_d;
    logic                spi_ack_q, spi_ack_d;
    logic                fw_ack_q, fw_ack_d;
    logic [DATA_W-1:0]   spi_rdata_q, spi_rdata_d;
    logic [DATA_W-1:0]   fw_rdata_q, fw_rdata_d;

    // Arbitration: FW wins when alone or when SPI has starved it long enough.
    logic              grant_fw_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    assign grant_fw_c  = fw_req_i & (~spi_req_i | (starve_q == STARVE_LIM));
    assign sel_we_c    = grant_fw_c ? fw_we_i    : spi_we_i;
    assign sel_addr_c  = grant_fw_c ? fw_addr_i  : spi_addr_i;
    assign sel_wdata_c = grant_fw_c ? fw_wdata_i : spi_wdata_i;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        spi_ack_d   = 1'b0;
        fw_ack_d    = 1'b0;
        spi_rdata_d = spi_rdata_q;
        fw_rdata_d  = fw_rdata_q;

        case (state_q)
            IDLE: begin
                // Starvation count only grows while FW is actually waiting.
                if (!fw_req_i || grant_fw_c) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_LIM) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
                if (spi_req_i || fw_req_i) begin
                    state_d  = ISSUE;
                    owner_d  = grant_fw_c ? OWNER_FW : OWNER_SPI;
                    we_d     = sel_we_c;
                    addr_d   = sel_addr_c;
                    wdata_d  = sel_wdata_c;
                    reg_wr_d = sel_we_c;
                    reg_rd_d = ~sel_we_c;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d   = ACK;
                    spi_ack_d = (owner_q == OWNER_SPI);
                    fw_ack_d  = (owner_q == OWNER_FW);
                end else begin
                    state_d = RWAIT;
                    lat_d   = LAT_W'(1);
                end
            end
            RWAIT: begin
                // lat_q counts cycles since ISSUE; capture on the last one.
                if (lat_q == LAT_LAST) begin
                    state_d   = ACK;
                    spi_ack_d = (owner_q == OWNER_SPI);
                    fw_ack_d  = (owner_q == OWNER_FW);
                    if (owner_q == OWNER_SPI) begin
                        spi_rdata_d = reg_rdata_i;
                    end else begin
                        fw_rdata_d = reg_rdata_i;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
                addr_d  = '0;
                wdata_d = '0;
                lat_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_SPI;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_q       <= '0;
            starve_q    <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            spi_ack_q   <= 1'b0;
            fw_ack_q    <= 1'b0;
            spi_rdata_q <= '0;
            fw_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            spi_ack_q   <= spi_ack_d;
            fw_ack_q    <= fw_ack_d;
            spi_rdata_q <= spi_rdata_d;
            fw_rdata_q  <= fw_rdata_d;
        end
    end

    // Strobes and acks are masked during reset so none is seen in a reset cycle.
    assign reg_wr_o    = reg_wr_q  & ~reset_i;
    assign reg_rd_o    = reg_rd_q  & ~reset_i;
    assign spi_ack_o   = spi_ack_q & ~reset_i;
    assign fw_ack_o    = fw_ack_q  & ~reset_i;
    assign reg_addr_o  = addr_q;
    assign reg_data_o  = wdata_q;
    assign spi_rdata_o = spi_rdata_q;
    assign fw_rdata_o  = fw_rdata_q;

    // Hold off the SPI front-end until its own access reaches ACK.
    assign spi_wait_o  = spi_req_i & ~((state_q == ACK) & (owner_q == OWNER_SPI));

endmodule

// File: tb/tb_tpm_reg_arbiter.sv
// Testbench for tpm_reg_arbiter: directed and random accesses checked through
// a strobe scoreboard and an ack scoreboard, with latency and reset checks.
module tb_tpm_reg_arbiter;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              spi_req_i = 1'b0, spi_we_i = 1'b0;
    logic [ADDR_W-1:0] spi_addr_i = '0;
    logic [DATA_W-1:0] spi_wdata_i = '0;
    logic              spi_ack_o, spi_wait_o;
    logic [DATA_W-1:0] spi_rdata_o;
    logic              fw_req_i = 1'b0, fw_we_i = 1'b0;
    logic [ADDR_W-1:0] fw_addr_i = '0;
    logic [DATA_W-1:0] fw_wdata_i = '0;
    logic              fw_ack_o;
    logic [DATA_W-1:0] fw_rdata_o;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [DATA_W-1:0] reg_data_o;
    logic              reg_wr_o, reg_rd_o;
    logic [DATA_W-1:0] reg_rdata_i;

    tpm_reg_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .spi_req_i(spi_req_i), .spi_we_i(spi_we_i), .spi_addr_i(spi_addr_i),
        .spi_wdata_i(spi_wdata_i), .spi_ack_o(spi_ack_o), .spi_rdata_o(spi_rdata_o),
        .spi_wait_o(spi_wait_o),
        .fw_req_i(fw_req_i), .fw_we_i(fw_we_i), .fw_addr_i(fw_addr_i),
        .fw_wdata_i(fw_wdata_i), .fw_ack_o(fw_ack_o), .fw_rdata_o(fw_rdata_o),
        .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o), .reg_wr_o(reg_wr_o),
        .reg_rd_o(reg_rd_o), .reg_rdata_i(reg_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_f(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h8B;
    endfunction

    // Register-file model: read data valid only in cycle ISSUE+RD_LAT.
    logic [3:0] rd_dly = 4'b0;
    always @(posedge clk) rd_dly <= {rd_dly[2:0], reg_rd_o};
    assign reg_rdata_i = rd_dly[RD_LAT-1] ? rd_f(reg_addr_o) : 8'hEE;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } strb_t;
    typedef struct {
        logic              owner;
        logic              we;
        logic [DATA_W-1:0] rdata;
    } ack_t;

    strb_t strb_q[$];
    ack_t  ack_q[$];
    logic [DATA_W-1:0] exp_spi_rdata = '0;
    logic [DATA_W-1:0] exp_fw_rdata  = '0;
    int last_strobe_cyc = -1;

    task automatic push_exp(input logic fw, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input bit with_ack);
        strb_t s;
        ack_t  k;
        s.we = we; s.addr = a; s.data = d;
        strb_q.push_back(s);
        if (with_ack) begin
            k.owner = fw; k.we = we; k.rdata = rd_f(a);
            ack_q.push_back(k);
        end
    endtask

    // Monitor: strobes and acks popped against the scoreboards.
    always @(negedge clk) begin
        strb_t s;
        ack_t  k;
        if (reset_i) begin
            chk("rst_quiet", {28'd0, reg_wr_o, reg_rd_o, spi_ack_o, fw_ack_o}, 32'd0);
        end
        if (reg_wr_o || reg_rd_o) begin
            chk("strobe_excl", 32'(reg_wr_o & reg_rd_o), 32'd0);
            last_strobe_cyc = cyc;
            if (strb_q.size() == 0) begin
                chk("strobe_unexp", 32'(reg_wr_o | reg_rd_o), 32'd0);
            end else begin
                s = strb_q.pop_front();
                chk("strobe_we", 32'(reg_wr_o), 32'(s.we));
                chk("strobe_addr", 32'(reg_addr_o), 32'(s.addr));
                chk("strobe_data", 32'(reg_data_o), 32'(s.data));
            end
        end
        if (spi_ack_o || fw_ack_o) begin
            chk("ack_excl", 32'(spi_ack_o & fw_ack_o), 32'd0);
            if (ack_q.size() == 0) begin
                chk("ack_unexp", {30'd0, spi_ack_o, fw_ack_o}, 32'd0);
            end else begin
                k = ack_q.pop_front();
                chk("ack_owner", 32'(fw_ack_o), 32'(k.owner));
                if (!k.we) begin
                    if (k.owner) exp_fw_rdata = k.rdata;
                    else         exp_spi_rdata = k.rdata;
                end
                chk("spi_rdata", 32'(spi_rdata_o), 32'(exp_spi_rdata));
                chk("fw_rdata", 32'(fw_rdata_o), 32'(exp_fw_rdata));
            end
        end
    end

    task automatic set_req(input logic fw, input logic req, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (fw) begin
            fw_req_i = req; fw_we_i = we; fw_addr_i = a; fw_wdata_i = d;
        end else begin
            spi_req_i = req; spi_we_i = we; spi_addr_i = a; spi_wdata_i = d;
        end
    endtask

    // Wait (bounded) for the owner's ack; leaves the caller at the ack negedge.
    task automatic wait_ack(input logic fw, input int n, input int lat, input bit chk_wait,
                            output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (chk_wait) chk("spi_wait", 32'(spi_wait_o), 32'((cyc - n) != lat));
            if (fw ? fw_ack_o : spi_ack_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic access(input logic fw, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input bit withdraw);
        int n;
        int lat;
        bit got;
        lat = we ? 2 : 2 + RD_LAT;
        @(posedge clk); #1;
        n = cyc;
        push_exp(fw, we, a, d, 1'b1);
        set_req(fw, 1'b1, we, a, d);
        if (withdraw) begin
            @(posedge clk); #1;
            set_req(fw, 1'b0, we, a, d);
        end
        wait_ack(fw, n, lat, !fw && !withdraw, got);
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_lat", 32'(cyc - n), 32'(lat));
        chk("strobe_cyc", 32'(last_strobe_cyc - n), 32'd1);
        @(posedge clk); #1;
        set_req(fw, 1'b0, we, a, d);
        @(negedge clk);
        chk("idle_bus", {8'd0, reg_addr_o, reg_data_o}, 32'd0);
    endtask

    initial begin
        int  n;
        int  acks;
        bit  got;
        logic ord [10];
        logic [ADDR_W-1:0] ra;

        // Reset and reset-state outputs.
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_outs", {22'd0, spi_ack_o, fw_ack_o, reg_wr_o, reg_rd_o, spi_wait_o,
                         |reg_addr_o, |reg_data_o, |spi_rdata_o, |fw_rdata_o, 1'b0}, 32'd0);

        // SPI read to make spi_rdata non-zero, then basic write / FW accesses.
        access(1'b0, 1'b0, 16'h0011, 8'h00, 1'b0);
        access(1'b0, 1'b1, 16'h0000, 8'h02, 1'b0);
        access(1'b1, 1'b0, 16'h0008, 8'h00, 1'b0);
        chk("fw_rd_0x83", 32'(fw_rdata_o), 32'h83);
        chk("spi_rd_kept", 32'(spi_rdata_o), 32'h9A);
        access(1'b1, 1'b1, 16'h0123, 8'h5C, 1'b0);

        // Both requesters held high: SPI granted STARVE_MAX times, then FW.
        ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            push_exp(ord[i], 1'b1, ord[i] ? 16'h0F00 : 16'h0500, ord[i] ? 8'hF0 : 8'h50, 1'b1);
        end
        @(posedge clk); #1;
        n = cyc;
        set_req(1'b0, 1'b1, 1'b1, 16'h0500, 8'h50);
        set_req(1'b1, 1'b1, 1'b1, 16'h0F00, 8'hF0);
        acks = 0;
        for (int i = 0; i < 200 && acks < 10; i++) begin
            @(negedge clk);
            if (spi_ack_o || fw_ack_o) acks++;
        end
        chk("starve_acks", 32'(acks), 32'd10);
        chk("starve_span", 32'(cyc - n), 32'd29);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b1, 16'h0500, 8'h50);
        set_req(1'b1, 1'b0, 1'b1, 16'h0F00, 8'hF0);
        repeat (2) @(posedge clk);

        // Reset during RWAIT of an SPI read: aborted, then re-issued.
        @(posedge clk); #1;
        n = cyc;
        push_exp(1'b0, 1'b0, 16'h0040, 8'h11, 1'b0);
        push_exp(1'b0, 1'b0, 16'h0040, 8'h11, 1'b1);
        set_req(1'b0, 1'b1, 1'b0, 16'h0040, 8'h11);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        exp_spi_rdata = '0;
        exp_fw_rdata  = '0;
        chk("rst_mid_outs", {spi_rdata_o, fw_rdata_o, reg_addr_o}, 32'd0);
        chk("rst_mid_strb", {28'd0, reg_wr_o, reg_rd_o, spi_ack_o, fw_ack_o}, 32'd0);
        wait_ack(1'b0, n, 7, 1'b0, got);
        chk("rst_reissue_ack", 32'(got), 32'd1);
        chk("rst_reissue_lat", 32'(cyc - n), 32'd7);
        chk("rst_reissue_data", 32'(spi_rdata_o), 32'(rd_f(16'h0040)));
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0040, 8'h11);

        // SPI read withdrawn during ISSUE, then an FW write.
        access(1'b0, 1'b0, 16'h0023, 8'h00, 1'b1);
        access(1'b1, 1'b1, 16'h0031, 8'h7C, 1'b0);

        // Random single-requester traffic.
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(0, 16'hFFFF));
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                   8'($urandom_range(0, 255)), 1'b0);
        end

        repeat (6) @(posedge clk);
        chk("sb_empty", 32'(ack_q.size() + strb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
